// File: rtl/garnet_irq_pkg.sv
// Shared types and constants for the garnet interrupt request generator.
package garnet_irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_WAIT = 2'd1,
    ACTIVE   = 2'd2,
    CLR_WAIT = 2'd3
  } irq_state_t;

  // Width of the shell's irq_req/irq_ack bus
  localparam int IRQ_BUS_W = 16;

  // Default ack-timeout in clk cycles
  localparam int ACK_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/garnet_irq_chan.sv
// One interrupt channel: request/acknowledge handshake FSM toward the shell.
// Optional ack timeout is built in when GARNET_IRQ_ACK_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no request outstanding, req=0, waiting for effective source
// SET_WAIT | req=1 raised, waiting for the shell to ack the rise
// ACTIVE   | rise acknowledged, req=1 held while the source stays high
// CLR_WAIT | req=0 dropped, waiting for the shell to ack the fall
module garnet_irq_chan
  import garnet_irq_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int TMO_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic areset,
  input  logic i_eff,
  input  logic i_ack,
  input  logic i_err_clr,
  output logic o_req,
  output logic o_pending,
  output logic o_ack_err
);

  irq_state_t r_state;
  irq_state_t w_state_nxt;
  logic       r_req;
  logic       r_pending;
  logic       w_tmo;

`ifdef GARNET_IRQ_ACK_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_ack_err;
  logic             w_in_wait;
  logic             w_wait_entry;

  assign w_in_wait    = (r_state == SET_WAIT) || (r_state == CLR_WAIT);
  assign w_wait_entry = ((w_state_nxt == SET_WAIT) && (r_state != SET_WAIT)) ||
                        ((w_state_nxt == CLR_WAIT) && (r_state != CLR_WAIT));
  // An ack arriving in the same cycle as the limit still wins over the timeout
  assign w_tmo        = w_in_wait && !i_ack && (r_tmo_cnt == TMO_LIMIT);

  // Wait-state cycle counter: restarts on each wait entry, saturates at the limit
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_tmo_cnt <= '0;
    end else if (w_wait_entry) begin
      r_tmo_cnt <= '0;
    end else if (w_in_wait && (r_tmo_cnt != TMO_LIMIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_ack_err <= 1'b0;
    end else if (w_tmo) begin
      r_ack_err <= 1'b1;
    end else if (i_err_clr) begin
      r_ack_err <= 1'b0;
    end
  end

  assign o_ack_err = r_ack_err;
`else
  logic w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign o_ack_err    = 1'b0;
  assign w_unused_tmo = ^{i_err_clr, ACK_TIMEOUT[0], TMO_W[0]};
`endif

  // Next-state decode; ack is consumed before the source level is looked at
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (i_eff) w_state_nxt = SET_WAIT;
      SET_WAIT: begin
        if (i_ack)      w_state_nxt = ACTIVE;
        else if (w_tmo) w_state_nxt = IDLE;
      end
      ACTIVE:   if (!i_eff) w_state_nxt = CLR_WAIT;
      CLR_WAIT: begin
        if (i_ack)      w_state_nxt = IDLE;
        else if (w_tmo) w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= (w_state_nxt == SET_WAIT) || (w_state_nxt == ACTIVE);
      r_pending <= (w_state_nxt != IDLE);
    end
  end

  assign o_req     = r_req;
  assign o_pending = r_pending;

endmodule

// File: rtl/garnet_irq_gen.sv
// Interrupt request generator: NUM_IRQ independent handshake channels driving
// the shell's 16-bit irq_req/irq_ack bus. Optional ack timeout is enabled by
// defining GARNET_IRQ_ACK_TIMEOUT_EN.
module garnet_irq_gen
  import garnet_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 16,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int TMO_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [NUM_IRQ-1:0]   irq_src,
  input  logic [NUM_IRQ-1:0]   irq_mask,
  output logic [IRQ_BUS_W-1:0] irq_req,
  input  logic [IRQ_BUS_W-1:0] irq_ack,
  output logic [NUM_IRQ-1:0]   irq_pending,
  output logic [NUM_IRQ-1:0]   irq_ack_err,
  input  logic [NUM_IRQ-1:0]   irq_err_clr
);

  logic [NUM_IRQ-1:0] w_eff;
  logic [NUM_IRQ-1:0] w_req;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_ack_err;

  assign w_eff = irq_src & irq_mask;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    garnet_irq_chan #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .TMO_W       (TMO_W)
    ) u_chan (
      .clk       (clk),
      .areset    (areset),
      .i_eff     (w_eff[g]),
      .i_ack     (irq_ack[g]),
      .i_err_clr (irq_err_clr[g]),
      .o_req     (w_req[g]),
      .o_pending (w_pending[g]),
      .o_ack_err (w_ack_err[g])
    );
  end

  if (NUM_IRQ < IRQ_BUS_W) begin : g_unused_ack
    logic w_unused_ack;
    assign w_unused_ack = ^irq_ack[IRQ_BUS_W-1:NUM_IRQ];
  end

  // Widen to the shell bus; bits without a channel stay low
  always_comb begin
    irq_req                = '0;
    irq_req[NUM_IRQ-1:0]   = w_req;
  end

  assign irq_pending = w_pending;
  assign irq_ack_err = w_ack_err;

endmodule
